// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the uart_interface transceiver.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Bit period in system clocks (truncating division).
  function automatic int calc_clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

  // Parity bit that makes data+parity hold an even (mode 0) or odd (mode 1) number of ones.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: receive FSM with mid-bit sampling, optional parity check and
// framing-error recovery. rx_line must already be synchronous to clk.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_line,
  input  logic                      parity_en,
  input  logic                      parity_mode,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_ready,
  output logic                      parity_error
);

  localparam int                CNT_W         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST      = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [2:0]                bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [UART_DATA_BITS-1:0] data_reg, data_next;
  logic                      prev_reg;
  logic                      pen_reg, pen_next;
  logic                      pmode_reg, pmode_next;
  logic                      par_bit_reg, par_bit_next;
  logic                      ready_reg, ready_next;
  logic                      perr_reg, perr_next;
  logic                      cnt_last;

  assign cnt_last = (cnt_reg == CNT_LAST);

  // State and datapath registers; prev_reg tracks the line for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      prev_reg    <= UART_IDLE_LEVEL;
      pen_reg     <= 1'b0;
      pmode_reg   <= 1'b0;
      par_bit_reg <= 1'b0;
      ready_reg   <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      prev_reg    <= rx_line;
      pen_reg     <= pen_next;
      pmode_reg   <= pmode_next;
      par_bit_reg <= par_bit_next;
      ready_reg   <= ready_next;
      perr_reg    <= perr_next;
    end
  end

  // Next-state logic: half-bit start confirmation, then one sample per bit period.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    pen_next     = pen_reg;
    pmode_next   = pmode_reg;
    par_bit_next = par_bit_reg;
    ready_next   = 1'b0;
    perr_next    = perr_reg;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (prev_reg && !rx_line) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == CNT_HALF_LAST) begin
          cnt_next = '0;
          if (rx_line) begin
            // Line came back high: glitch, not a start bit.
            state_next = RX_IDLE;
          end else begin
            state_next   = RX_DATA;
            bit_idx_next = '0;
            pen_next     = parity_en;
            pmode_next   = parity_mode;
          end
        end
      end
      RX_DATA: begin
        if (cnt_last) begin
          cnt_next   = '0;
          shift_next = {rx_line, shift_reg[UART_DATA_BITS-1:1]};
          if (bit_idx_reg == BIT_LAST) state_next = pen_reg ? RX_PARITY : RX_STOP;
          else                         bit_idx_next = bit_idx_reg + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_last) begin
          cnt_next     = '0;
          par_bit_next = rx_line;
          state_next   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (rx_line) begin
            data_next  = shift_reg;
            ready_next = 1'b1;
            perr_next  = pen_reg & (par_bit_reg != calc_parity(shift_reg, pmode_reg));
            state_next = RX_IDLE;
          end else begin
            // Framing error: drop the byte and wait for the line to recover.
            state_next = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_line) state_next = RX_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = RX_IDLE;
      end
    endcase
  end

  assign rx_data      = data_reg;
  assign rx_ready     = ready_reg;
  assign parity_error = perr_reg;

endmodule

// File: rtl/uart_interface.sv
// uart_interface: full-duplex 8N1 / 8E1 / 8O1 UART. TX FSM, loopback mux and
// optional RX synchronizer live here; the receiver is uart_rx_core.
// Build option: define UART_RX_SYNC_EN to pass the selected RX line through a
// 2-flop synchronizer (adds 2 cycles of RX latency).
// CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE must be at least 4.
// Note: rst_n is active-HIGH despite its name.
module uart_interface
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 200_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data_in,
  input  logic                      rx_serial_in,
  input  logic                      db_rx_serial_in,
  input  logic                      parity_en,
  input  logic                      parity_mode,
  output logic                      tx_serial_out,
  output logic                      tx_busy,
  output logic [UART_DATA_BITS-1:0] rx_data_out,
  output logic                      rx_ready,
  output logic                      parity_error
);

  localparam int               CLKS_PER_BIT = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST     = 3'(UART_DATA_BITS - 1);

  tx_state_t                 tx_state_reg, tx_state_next;
  logic [CNT_W-1:0]          tx_cnt_reg, tx_cnt_next;
  logic [2:0]                tx_bit_idx_reg, tx_bit_idx_next;
  logic [UART_DATA_BITS-1:0] tx_data_reg, tx_data_next;
  logic                      tx_pen_reg, tx_pen_next;
  logic                      tx_par_reg, tx_par_next;
  logic                      tx_line_reg, tx_line_next;
  logic                      tx_start_d_reg;
  logic                      tx_accept;
  logic                      tx_cnt_last;
  logic                      rx_sel;
  logic                      rx_line;

  assign tx_accept   = tx_start & ~tx_start_d_reg & (tx_state_reg == TX_IDLE);
  assign tx_cnt_last = (tx_cnt_reg == CNT_LAST);

  // TX registers; the serial line itself is registered so the pin is glitch-free.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_reg   <= TX_IDLE;
      tx_cnt_reg     <= '0;
      tx_bit_idx_reg <= '0;
      tx_data_reg    <= '0;
      tx_pen_reg     <= 1'b0;
      tx_par_reg     <= 1'b0;
      tx_line_reg    <= UART_IDLE_LEVEL;
      tx_start_d_reg <= 1'b0;
    end else begin
      tx_state_reg   <= tx_state_next;
      tx_cnt_reg     <= tx_cnt_next;
      tx_bit_idx_reg <= tx_bit_idx_next;
      tx_data_reg    <= tx_data_next;
      tx_pen_reg     <= tx_pen_next;
      tx_par_reg     <= tx_par_next;
      tx_line_reg    <= tx_line_next;
      tx_start_d_reg <= tx_start;
    end
  end

  // TX next-state logic; the wire level is derived from the state being entered
  // so the start bit appears the cycle after acceptance.
  always_comb begin
    tx_state_next   = tx_state_reg;
    tx_cnt_next     = tx_cnt_reg + 1'b1;
    tx_bit_idx_next = tx_bit_idx_reg;
    tx_data_next    = tx_data_reg;
    tx_pen_next     = tx_pen_reg;
    tx_par_next     = tx_par_reg;
    tx_line_next    = UART_IDLE_LEVEL;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (tx_accept) begin
          tx_state_next = TX_START;
          tx_data_next  = tx_data_in;
          tx_pen_next   = parity_en;
          tx_par_next   = calc_parity(tx_data_in, parity_mode);
        end
      end
      TX_START: begin
        if (tx_cnt_last) begin
          tx_cnt_next     = '0;
          tx_bit_idx_next = '0;
          tx_state_next   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_last) begin
          tx_cnt_next = '0;
          if (tx_bit_idx_reg == BIT_LAST) tx_state_next = tx_pen_reg ? TX_PARITY : TX_STOP;
          else                            tx_bit_idx_next = tx_bit_idx_reg + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_last) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_last) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
        end
      end
      default: begin
        tx_cnt_next   = '0;
        tx_state_next = TX_IDLE;
      end
    endcase

    case (tx_state_next)
      TX_START:  tx_line_next = 1'b0;
      TX_DATA:   tx_line_next = tx_data_next[tx_bit_idx_next];
      TX_PARITY: tx_line_next = tx_par_next;
      default:   tx_line_next = UART_IDLE_LEVEL;
    endcase
  end

  assign tx_serial_out = tx_line_reg;
  assign tx_busy       = (tx_state_reg != TX_IDLE);

  // Debug loopback feeds the receiver from our own TX pin.
  assign rx_sel = db_rx_serial_in ? tx_line_reg : rx_serial_in;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_reg;

  // Two-flop synchronizer for the asynchronous RX pin, idling high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rx_sync_reg <= {2{UART_IDLE_LEVEL}};
    else       rx_sync_reg <= {rx_sync_reg[0], rx_sel};
  end

  assign rx_line = rx_sync_reg[1];
`else
  assign rx_line = rx_sel;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_core (
    .clk         (clk),
    .rst         (rst_n),
    .rx_line     (rx_line),
    .parity_en   (parity_en),
    .parity_mode (parity_mode),
    .rx_data     (rx_data_out),
    .rx_ready    (rx_ready),
    .parity_error(parity_error)
  );

endmodule

// File: tb/tb_uart_interface.sv
// tb_uart_interface: table-driven RX vectors, TX wire checks against a frame
// model, external/internal loopback with random bytes, and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_interface;

  localparam int CLOCK_RATE = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int CPB        = CLOCK_RATE / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       rx_serial_in;
  logic       db_rx_serial_in;
  logic       parity_en;
  logic       parity_mode;
  logic       tx_serial_out;
  logic       tx_busy;
  logic [7:0] rx_data_out;
  logic       rx_ready;
  logic       parity_error;

  logic ext_loop;
  logic rx_drive;

  assign rx_serial_in = ext_loop ? tx_serial_out : rx_drive;

  always #5 clk = ~clk;

  uart_interface #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_start       (tx_start),
    .tx_data_in     (tx_data_in),
    .rx_serial_in   (rx_serial_in),
    .db_rx_serial_in(db_rx_serial_in),
    .parity_en      (parity_en),
    .parity_mode    (parity_mode),
    .tx_serial_out  (tx_serial_out),
    .tx_busy        (tx_busy),
    .rx_data_out    (rx_data_out),
    .rx_ready       (rx_ready),
    .parity_error   (parity_error)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
  } rx_ev_t;

  rx_ev_t rx_q[$];
  rx_ev_t mon_ev;

  // Every rx_ready cycle becomes one queue entry, so a stretched pulse shows up as extra entries.
  always @(negedge clk) begin
    if (rx_ready) begin
      mon_ev.d  = rx_data_out;
      mon_ev.pe = parity_error;
      rx_q.push_back(mon_ev);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference frame: index k is wire bit k. Parity chosen from the count of ones.
  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic pen, input logic pm,
                                              input logic flip, input logic stop);
    logic [10:0] fr;
    logic        par;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = d[i];
    par = ((($countones(d) % 2) != 0) ? 1'b1 : 1'b0) ^ pm ^ flip;
    if (pen) begin
      fr[9]  = par;
      fr[10] = stop;
    end else begin
      fr[9]  = stop;
    end
    return fr;
  endfunction

  // Drive one frame on rx_serial_in followed by two idle bit times. Called at a negedge.
  task automatic drive_rx(input logic [7:0] d, input logic pen, input logic pm,
                          input logic flip, input logic stop);
    logic [10:0] fr;
    int          n;
    fr = build_frame(d, pen, pm, flip, stop);
    n  = pen ? 11 : 10;
    parity_en   = pen;
    parity_mode = pm;
    for (int k = 0; k < n; k++) begin
      rx_drive = fr[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Request one TX frame and check every wire bit mid-bit, busy edges and (optionally) the echo.
  task automatic send_tx(input logic [7:0] d, input logic pen, input logic pm, input int hold,
                         input bit repulse, input bit chk_rx, input string tag);
    logic [10:0] fr;
    int          n;
    rx_ev_t      ev;
    fr = build_frame(d, pen, pm, 1'b0, 1'b1);
    n  = pen ? 11 : 10;
    rx_q.delete();
    tx_data_in  = d;
    parity_en   = pen;
    parity_mode = pm;
    tx_start    = 1'b1;
    for (int c = 0; c < n * CPB; c++) begin
      @(negedge clk);
      if (c == hold - 1) tx_start = 1'b0;
      if (c == 1) tx_data_in = ~d;
      if (repulse && c == hold + 3) tx_start = 1'b1;
      if (repulse && c == hold + 6) tx_start = 1'b0;
      if (c == 0) check({tag, " busy_rise"}, tx_busy, 1);
      if (c % CPB == CPB / 2) check($sformatf("%s wire_bit%0d", tag, c / CPB), tx_serial_out, fr[c / CPB]);
    end
    check({tag, " busy_last"}, tx_busy, 1);
    @(negedge clk);
    check({tag, " busy_fall"}, tx_busy, 0);
    if (repulse) begin
      repeat (3) @(negedge clk);
      check({tag, " no_queued_frame"}, tx_busy, 0);
    end
    if (chk_rx) begin
      check({tag, " rx_count"}, rx_q.size(), 1);
      if (rx_q.size() > 0) begin
        ev = rx_q.pop_front();
        check({tag, " rx_data"}, ev.d, d);
        check({tag, " rx_perr"}, ev.pe, 0);
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       pm;
    logic       flip;
    logic       stop;
    logic       exp_rdy;
    logic [7:0] exp_d;
    logic       exp_pe;
  } vec_t;

  vec_t   vecs[10];
  rx_ev_t ev;
  string  msg;
  logic [7:0] rd;
  logic       rpen, rpm;

  initial begin
    //          d      pen   pm    flip  stop  rdy   exp_d  exp_pe
    vecs[0] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1};
    vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[8] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[9] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0};

    rst_n           = 1'b1;
    tx_start        = 1'b0;
    tx_data_in      = 8'h00;
    db_rx_serial_in = 1'b0;
    parity_en       = 1'b0;
    parity_mode     = 1'b0;
    ext_loop        = 1'b0;
    rx_drive        = 1'b1;

    // Reset for 100 ns.
    repeat (10) @(negedge clk);
    check("reset wire_in_reset", tx_serial_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset tx_serial_out", tx_serial_out, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset rx_ready", rx_ready, 0);
    check("reset rx_data_out", rx_data_out, 8'h00);
    check("reset parity_error", parity_error, 0);

    // Table-driven RX frames on rx_serial_in.
    for (int i = 0; i < 10; i++) begin
      rx_q.delete();
      drive_rx(vecs[i].d, vecs[i].pen, vecs[i].pm, vecs[i].flip, vecs[i].stop);
      check($sformatf("vec%0d rdy_count", i), rx_q.size(), vecs[i].exp_rdy);
      if (rx_q.size() > 0) begin
        ev = rx_q.pop_front();
        check($sformatf("vec%0d ev_data", i), ev.d, vecs[i].exp_d);
        check($sformatf("vec%0d ev_perr", i), ev.pe, vecs[i].exp_pe);
      end
      check($sformatf("vec%0d rx_data_out", i), rx_data_out, vecs[i].exp_d);
      check($sformatf("vec%0d parity_error", i), parity_error, vecs[i].exp_pe);
    end

    // False start: a low glitch shorter than half a bit yields nothing.
    rx_q.delete();
    rx_drive = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("false_start rdy_count", rx_q.size(), 0);
    check("false_start rx_data_out", rx_data_out, 8'h5A);

    // External loopback: "Hello, World!" back to back, parity off.
    ext_loop = 1'b1;
    msg = "Hello, World!";
    for (int i = 0; i < msg.len(); i++) begin
      send_tx(msg[i], 1'b0, 1'b0, 1, 1'b0, 1'b1, $sformatf("hello%0d", i));
    end

    // Long request plus an ignored edge while busy: exactly one 0x55 frame.
    send_tx(8'h55, 1'b0, 1'b0, 10, 1'b1, 1'b1, "long_req");

    // Even parity on 0x07: parity bit 1 on the wire, clean receive.
    send_tx(8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b1, "par_07");

    // Random bytes and parity settings through the loop.
    for (int i = 0; i < 12; i++) begin
      rd   = 8'($urandom);
      rpen = 1'($urandom_range(0, 1));
      rpm  = 1'($urandom_range(0, 1));
      send_tx(rd, rpen, rpm, $urandom_range(1, 20), 1'b0, 1'b1, $sformatf("rand%0d", i));
    end

    // Internal loopback with the external pin parked high.
    ext_loop        = 1'b0;
    rx_drive        = 1'b1;
    db_rx_serial_in = 1'b1;
    send_tx(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1, "int_loop");

    // Mid-frame reset while D0 (0) is on the wire.
    rx_q.delete();
    tx_data_in = 8'h3C;
    parity_en  = 1'b0;
    tx_start   = 1'b1;
    repeat (CPB + CPB / 2) @(negedge clk);
    tx_start = 1'b0;
    check("midrst wire_before", tx_serial_out, 0);
    rst_n = 1'b1;
    #1;
    check("midrst wire_now", tx_serial_out, 1);
    check("midrst busy_now", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("midrst rdy_count", rx_q.size(), 0);
    check("midrst busy_after", tx_busy, 0);
    check("midrst wire_after", tx_serial_out, 1);
    check("midrst rx_data_out", rx_data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_interface.md
# uart_interface

Full-duplex 8-bit UART transceiver with optional parity, sitting between on-chip byte-wide logic and an external serial pin pair (e.g. an NMEA GPS receiver at 9600 baud). A byte handed over with `tx_start` is serialized on `tx_serial_out`. Frames arriving on the RX line are deserialized and presented with a one-cycle `rx_ready` strobe plus a parity status flag. TX and RX run fully independently on one clock domain.

## Interface
- `CLOCK_RATE`, default 200_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate. Derived `CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE` (integer division; 20833 at defaults). Must be ≥ 4.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-high reset (1 = reset asserted, despite the name).
- `tx_start` in 1: a rising edge while TX is idle requests transmission of `tx_data_in`.
- `tx_data_in` in 8: byte to transmit, latched on acceptance.
- `rx_serial_in` in 1: serial RX line, idle high.
- `db_rx_serial_in` in 1: debug loopback select. 1 = RX internally takes `tx_serial_out`; 0 = RX takes `rx_serial_in`.
- `parity_en` in 1: 1 = append/expect a parity bit after the data bits.
- `parity_mode` in 1: 0 = even parity, 1 = odd parity.
- `tx_serial_out` out 1: serial TX line, registered.
- `tx_busy` out 1: high while a TX frame is in progress.
- `rx_data_out` out 8: last received byte, held until the next valid frame.
- `rx_ready` out 1: one-cycle pulse when `rx_data_out` is updated.
- `parity_error` out 1: parity status of the last received frame, updated with `rx_ready`.

## Operation
- **Frame format:** start bit (0), data bits D0..D7 LSB first, optional parity bit, one stop bit (1). The parity bit makes the count of ones over data plus parity even (mode 0) or odd (mode 1).
- **Reset values:** `tx_serial_out` = 1, `tx_busy` = 0, `rx_data_out` = 0x00, `rx_ready` = 0, `parity_error` = 0. Both FSMs go to IDLE and all counters clear.
- **TX FSM (IDLE → START → DATA → PARITY → STOP → IDLE):**
  - A rising edge of `tx_start` in IDLE latches `tx_data_in`, `parity_en` and `parity_mode`.
  - PARITY is skipped when `parity_en` = 0.
  - Each state lasts exactly `CLKS_PER_BIT` cycles.
  - `tx_start` edges while busy are ignored, not queued.
  - Holding `tx_start` high for many cycles yields exactly one frame.
- **RX FSM (IDLE → START → DATA → PARITY → STOP → IDLE, plus WAIT_IDLE):**
  - A falling edge on the RX line in IDLE enters START.
  - After `CLKS_PER_BIT/2` cycles the line is resampled. If it is high, the start is false: return to IDLE with no output.
  - Otherwise sample once per `CLKS_PER_BIT` (mid-bit) for D0..D7, then parity if enabled, then stop.
  - `parity_en` and `parity_mode` are captured at start-bit confirmation.
- **Stop bit = 1:** update `rx_data_out`, pulse `rx_ready`, and set `parity_error` to 1 on mismatch (forced 0 when parity is disabled).
- **Stop bit = 0 (framing error):** no `rx_ready`; `rx_data_out` and `parity_error` are unchanged. Go to WAIT_IDLE until the line is high, then IDLE.
- **Reset mid-frame:** the frame is abandoned immediately, `tx_serial_out` returns to 1, and no `rx_ready` is generated.

## Timing
- TX frame on the wire: start bit begins the cycle after acceptance. Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity).
- `tx_busy` rises the cycle after acceptance and falls the cycle the stop bit ends. A new `tx_start` edge is accepted in that same cycle.
- Back-to-back frames therefore have no gap beyond the request latency.
- `rx_ready` asserts the cycle after the mid-stop-bit sample and lasts exactly 1 cycle.
- Nominal RX latency from start-bit falling edge to `rx_ready`: 9.5 bit times (10.5 with parity) + 1 cycle, plus the synchronizer delay (see Configuration).

## Configuration
- `UART_RX_SYNC_EN` defined: the selected RX line passes through a 2-flop synchronizer (reset value 1) before edge detect and sampling, adding 2 cycles to RX latency.
- `UART_RX_SYNC_EN` undefined: the RX line is used directly, for synchronous or loopback-only use. Functional behaviour is otherwise identical.

## Structure
- Package `uart_pkg`:
  - TX and RX state enums.
  - Function computing `CLKS_PER_BIT`.
  - Parity helper (data, mode → parity bit).
  - Constants `UART_DATA_BITS` = 8 and `UART_IDLE_LEVEL` = 1.
- One sub-module, `uart_rx_core`: receiver FSM, mid-bit sampler and parity check.
- The TX FSM, loopback mux and optional synchronizer stay in the top level.

## Test plan
- **Reset:** assert `rst_n` = 1 for 100 ns, release → `tx_serial_out` = 1, `tx_busy` = 0, `rx_ready` = 0, `rx_data_out` = 0x00.
- **External loopback, parity off:** drive `tx_serial_out` into `rx_serial_in` and send "Hello, World!" (13 bytes, each requested once `tx_busy` falls) → 13 `rx_ready` pulses with bytes 0x48 … 0x21 in order; each frame 10×20833 cycles.
- **Long request:** hold `tx_start` high for 10 cycles with 0x55 → exactly one frame; wire pattern 0,1,0,1,0,1,0,1,0,1.
- **Parity:** `parity_en` = 1, `parity_mode` = 0, send 0x07 → parity bit 1 on the wire, `parity_error` = 0. Inject a flipped parity bit → `rx_ready` pulse with `parity_error` = 1.
- **Framing error:** drive a frame with stop bit 0 on `rx_serial_in` → no `rx_ready`, `rx_data_out` unchanged. A following valid 0xA5 frame → `rx_ready`, `rx_data_out` = 0xA5.
- **Internal loopback and mid-frame reset:** `db_rx_serial_in` = 1 with `rx_serial_in` held 1, send 0x3C → received 0x3C. Then assert reset mid-frame → `tx_serial_out` = 1 immediately and no `rx_ready`.
